// File: rtl/multi_timed_counter.sv
`default_nettype none
// ============================================================================
// Module   : multi_timed_counter
// Purpose  : One programmable interval timer gating NCH saturating up-counters.
//            At the end of every interval all channel counts are snapshotted
//            into held output registers together with per-channel overflow.
//            MODE "NORMAL" restarts the window immediately; MODE "ACKNOWLEDGE"
//            holds the snapshot (and stops counting) until ack.
// Ports    : clk             - only clock
//            rst_n           - asynchronous active-low reset
//            count_in        - per-channel count enables (one bit per channel)
//            interval_in     - new interval length in clocks (0 = 2^INT_WIDTH)
//            interval_load   - capture interval_in and restart (dead cycle)
//            ack             - releases HOLD (ACKNOWLEDGE mode only)
//            count_out       - held snapshot, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//            count_ovf       - channel i saturated during the snapshotted window
//            count_out_valid - snapshot available (pulse or level, by MODE)
// Revision : 1.0 - initial release
// ============================================================================
module multi_timed_counter #(
  parameter int unsigned NCH           = 4,
  parameter int unsigned INT_WIDTH     = 24,
  parameter int unsigned CNT_WIDTH     = 25,
  parameter string       MODE          = "NORMAL",
  parameter int unsigned INIT_INTERVAL = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           count_in,
  input  logic [INT_WIDTH-1:0]     interval_in,
  input  logic                     interval_load,
  input  logic                     ack,
  output logic [NCH*CNT_WIDTH-1:0] count_out,
  output logic [NCH-1:0]           count_ovf,
  output logic                     count_out_valid
);

  localparam bit                   c_ack_mode = (MODE == "ACKNOWLEDGE");
  localparam bit                   c_mode_ok  = (MODE == "NORMAL") || c_ack_mode;
  localparam logic [INT_WIDTH-1:0] c_init_ivl = INT_WIDTH'(INIT_INTERVAL);
  localparam logic [INT_WIDTH-1:0] c_t_one    = {{(INT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_cnt_max  = {CNT_WIDTH{1'b1}};

  // Reject unsupported configurations at elaboration time.
  generate
    if (!c_mode_ok) begin : g_bad_mode
      $error("multi_timed_counter: MODE must be \"NORMAL\" or \"ACKNOWLEDGE\"");
    end
    if ((NCH < 1) || (NCH > 32)) begin : g_bad_nch
      $error("multi_timed_counter: NCH must be in 1..32");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                          r_state;
  logic [INT_WIDTH-1:0]            r_ivl;
  logic [INT_WIDTH-1:0]            r_t;
  logic [NCH-1:0][CNT_WIDTH-1:0]   r_acc;
  logic [NCH-1:0]                  r_sat;
  logic [NCH-1:0][CNT_WIDTH-1:0]   r_snap;
  logic [NCH-1:0]                  r_ovf;
  logic                            r_valid;

  logic [INT_WIDTH-1:0]            w_ivl_m1;
  logic                            w_last;
  logic [NCH-1:0][CNT_WIDTH-1:0]   w_acc_next;
  logic [NCH-1:0]                  w_clamp;

  // ivl - 1 wraps to all-ones for ivl == 0, giving a 2^INT_WIDTH window.
  assign w_ivl_m1 = r_ivl - c_t_one;
  assign w_last   = (r_t == w_ivl_m1);

  // Saturating increment per channel; w_clamp flags a count lost to the clamp.
  always_comb begin
    w_acc_next = r_acc;
    w_clamp    = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (count_in[i]) begin
        if (r_acc[i] == c_cnt_max) begin
          w_clamp[i] = 1'b1;
        end else begin
          w_acc_next[i] = r_acc[i] + c_cnt_one;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_ivl   <= c_init_ivl;
      r_t     <= '0;
      r_acc   <= '0;
      r_sat   <= '0;
      r_snap  <= '0;
      r_ovf   <= '0;
      r_valid <= 1'b0;
    end else if (interval_load) begin
      // Dead restart cycle: nothing counted, no snapshot, outputs retained.
      r_ivl   <= interval_in;
      r_t     <= '0;
      r_acc   <= '0;
      r_sat   <= '0;
      r_state <= ST_RUN;
      r_valid <= 1'b0;
    end else if (r_state == ST_HOLD) begin
      // Timer and accumulators already sit at 0; count_in is ignored here.
      if (ack) begin
        r_state <= ST_RUN;
        r_valid <= 1'b0;
      end
    end else if (w_last) begin
      // The snapshot includes this cycle's count_in.
      r_snap  <= w_acc_next;
      r_ovf   <= r_sat | w_clamp;
      r_acc   <= '0;
      r_sat   <= '0;
      r_t     <= '0;
      r_valid <= 1'b1;
      r_state <= c_ack_mode ? ST_HOLD : ST_RUN;
    end else begin
      r_t     <= r_t + c_t_one;
      r_acc   <= w_acc_next;
      r_sat   <= r_sat | w_clamp;
      r_valid <= 1'b0;
    end
  end

  assign count_out       = r_snap;
  assign count_ovf       = r_ovf;
  assign count_out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_multi_timed_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_timed_counter
// Purpose  : Self-checking bench for multi_timed_counter. Three instances:
//            A - NORMAL, NCH=4, INT_WIDTH=4, CNT_WIDTH=5, INIT_INTERVAL=0
//            B - ACKNOWLEDGE, NCH=4, INT_WIDTH=8, CNT_WIDTH=8, INIT_INTERVAL=3
//            C - NORMAL, NCH=2, INT_WIDTH=8, CNT_WIDTH=3, INIT_INTERVAL=10
//            A window-level model predicts every output each cycle; directed
//            literal expectations pin key points of the scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_timed_counter;

  logic clk;
  logic r_rst_n;

  logic [3:0]  r_cin_a;  logic [3:0] r_ivl_a;  logic r_load_a; logic r_ack_a;
  logic [3:0]  r_cin_b;  logic [7:0] r_ivl_b;  logic r_load_b; logic r_ack_b;
  logic [1:0]  r_cin_c;  logic [7:0] r_ivl_c;  logic r_load_c; logic r_ack_c;

  logic [19:0] w_out_a;  logic [3:0] w_ovf_a;  logic w_val_a;
  logic [31:0] w_out_b;  logic [3:0] w_ovf_b;  logic w_val_b;
  logic [5:0]  w_out_c;  logic [1:0] w_ovf_c;  logic w_val_c;

  multi_timed_counter #(.NCH(4), .INT_WIDTH(4), .CNT_WIDTH(5), .MODE("NORMAL"), .INIT_INTERVAL(0)) u_dut_a (
    .clk(clk), .rst_n(r_rst_n), .count_in(r_cin_a), .interval_in(r_ivl_a),
    .interval_load(r_load_a), .ack(r_ack_a),
    .count_out(w_out_a), .count_ovf(w_ovf_a), .count_out_valid(w_val_a));

  multi_timed_counter #(.NCH(4), .INT_WIDTH(8), .CNT_WIDTH(8), .MODE("ACKNOWLEDGE"), .INIT_INTERVAL(3)) u_dut_b (
    .clk(clk), .rst_n(r_rst_n), .count_in(r_cin_b), .interval_in(r_ivl_b),
    .interval_load(r_load_b), .ack(r_ack_b),
    .count_out(w_out_b), .count_ovf(w_ovf_b), .count_out_valid(w_val_b));

  multi_timed_counter #(.NCH(2), .INT_WIDTH(8), .CNT_WIDTH(3), .MODE("NORMAL"), .INIT_INTERVAL(10)) u_dut_c (
    .clk(clk), .rst_n(r_rst_n), .count_in(r_cin_c), .interval_in(r_ivl_c),
    .interval_load(r_load_c), .ack(r_ack_c),
    .count_out(w_out_c), .count_ovf(w_ovf_c), .count_out_valid(w_val_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance configuration for the model.
  localparam int c_nch  [3] = '{4, 4, 2};
  localparam int c_iw   [3] = '{4, 8, 8};
  localparam int c_cw   [3] = '{5, 8, 3};
  localparam int c_init [3] = '{0, 3, 10};
  localparam bit c_ack  [3] = '{1'b0, 1'b1, 1'b0};

  // Model state: window length, cycles elapsed in the window, counts.
  int m_len  [3];
  int m_pos  [3];
  int m_acc  [3][4];
  bit m_sat  [3][4];
  bit m_hold [3];
  int e_cnt  [3][4];
  bit e_ovf  [3][4];
  bit e_valid[3];

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic m_reset(input int k);
    m_len[k]   = (c_init[k] == 0) ? (1 << c_iw[k]) : c_init[k];
    m_pos[k]   = 0;
    m_hold[k]  = 1'b0;
    e_valid[k] = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      m_acc[k][ch] = 0; m_sat[k][ch] = 1'b0; e_cnt[k][ch] = 0; e_ovf[k][ch] = 1'b0;
    end
  endtask

  task automatic m_step(input int k, input logic [3:0] cin, input logic load,
                        input int ivl, input logic ackv);
    int maxv;
    maxv = (1 << c_cw[k]) - 1;
    if (load) begin
      m_len[k]   = (ivl == 0) ? (1 << c_iw[k]) : ivl;
      m_pos[k]   = 0;
      m_hold[k]  = 1'b0;
      e_valid[k] = 1'b0;
      for (int ch = 0; ch < 4; ch++) begin m_acc[k][ch] = 0; m_sat[k][ch] = 1'b0; end
    end else if (m_hold[k]) begin
      if (ackv) begin m_hold[k] = 1'b0; e_valid[k] = 1'b0; end
    end else begin
      for (int ch = 0; ch < c_nch[k]; ch++) begin
        if (cin[ch]) begin
          if (m_acc[k][ch] == maxv) m_sat[k][ch] = 1'b1;
          else m_acc[k][ch] = m_acc[k][ch] + 1;
        end
      end
      m_pos[k] = m_pos[k] + 1;
      if (m_pos[k] == m_len[k]) begin
        for (int ch = 0; ch < 4; ch++) begin
          e_cnt[k][ch] = m_acc[k][ch]; e_ovf[k][ch] = m_sat[k][ch];
          m_acc[k][ch] = 0; m_sat[k][ch] = 1'b0;
        end
        m_pos[k]   = 0;
        e_valid[k] = 1'b1;
        m_hold[k]  = c_ack[k];
      end else begin
        e_valid[k] = 1'b0;
      end
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int k);
    logic [63:0] v;
    v = '0;
    for (int ch = 0; ch < c_nch[k]; ch++) v = v | (64'(e_cnt[k][ch]) << (ch * c_cw[k]));
    return v;
  endfunction

  function automatic logic [63:0] exp_ovf(input int k);
    logic [63:0] v;
    v = '0;
    for (int ch = 0; ch < c_nch[k]; ch++) v[ch] = e_ovf[k][ch];
    return v;
  endfunction

  always @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      for (int k = 0; k < 3; k++) m_reset(k);
    end else begin
      m_step(0, r_cin_a, r_load_a, int'(r_ivl_a), r_ack_a);
      m_step(1, r_cin_b, r_load_b, int'(r_ivl_b), r_ack_b);
      m_step(2, {2'b00, r_cin_c}, r_load_c, int'(r_ivl_c), r_ack_c);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_cnt", 64'(w_out_a), exp_cnt(0)); chk("a_ovf", 64'(w_ovf_a), exp_ovf(0));
      chk("a_val", 64'(w_val_a), 64'(e_valid[0]));
      chk("b_cnt", 64'(w_out_b), exp_cnt(1)); chk("b_ovf", 64'(w_ovf_b), exp_ovf(1));
      chk("b_val", 64'(w_val_b), 64'(e_valid[1]));
      chk("c_cnt", 64'(w_out_c), exp_cnt(2)); chk("c_ovf", 64'(w_ovf_c), exp_ovf(2));
      chk("c_val", 64'(w_val_c), 64'(e_valid[2]));
    end
  end

  initial begin
    r_rst_n = 1'b0;
    r_cin_a = '0; r_ivl_a = '0; r_load_a = 1'b0; r_ack_a = 1'b0;
    r_cin_b = '0; r_ivl_b = '0; r_load_b = 1'b0; r_ack_b = 1'b0;
    r_cin_c = '0; r_ivl_c = '0; r_load_c = 1'b0; r_ack_c = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_a", 64'(w_out_a), 64'd0);
    chk("rst_val_b", 64'(w_val_b), 64'd0);
    chk("rst_ovf_c", 64'(w_ovf_c), 64'd0);
    cmp_en = 1'b1;
    #2 r_rst_n = 1'b1;

    // A: NORMAL, interval 4; ch0 every cycle, ch1 alternate cycles.
    @(negedge clk); r_load_a = 1'b1; r_ivl_a = 4'd4; r_cin_a = '0;
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      if (j == 4 || j == 8) begin
        chk("a4_val", 64'(w_val_a), 64'd1);
        chk("a4_cnt", 64'(w_out_a), 64'({5'd0, 5'd0, 5'd2, 5'd4}));
        chk("a4_ovf", 64'(w_ovf_a), 64'd0);
      end
      if (j == 5) begin
        chk("a4_pulse_end", 64'(w_val_a), 64'd0);
        chk("a4_held", 64'(w_out_a), 64'({5'd0, 5'd0, 5'd2, 5'd4}));
      end
      r_load_a = 1'b0;
      r_cin_a  = (j % 2 == 0) ? 4'b0011 : 4'b0001;
    end

    // A: interval 0 means 16 cycles; all channels high.
    @(negedge clk); r_load_a = 1'b1; r_ivl_a = 4'd0; r_cin_a = '0;
    for (int j = 0; j <= 16; j++) begin
      @(negedge clk);
      if (j == 15) chk("a0_not_yet", 64'(w_val_a), 64'd0);
      if (j == 16) begin
        chk("a0_val", 64'(w_val_a), 64'd1);
        chk("a0_cnt", 64'(w_out_a), 64'({5'd16, 5'd16, 5'd16, 5'd16}));
      end
      r_load_a = 1'b0;
      r_cin_a  = 4'b1111;
    end

    // A: interval 6, then load 2 on the last cycle of the second window.
    @(negedge clk); r_load_a = 1'b1; r_ivl_a = 4'd6; r_cin_a = '0;
    for (int j = 0; j <= 14; j++) begin
      @(negedge clk);
      if (j == 6) chk("a6_cnt", 64'(w_out_a), 64'({5'd0, 5'd0, 5'd0, 5'd6}));
      if (j == 12) begin
        chk("a6_load_noval", 64'(w_val_a), 64'd0);
        chk("a6_load_keep", 64'(w_out_a), 64'({5'd0, 5'd0, 5'd0, 5'd6}));
      end
      if (j == 14) begin
        chk("a2_val", 64'(w_val_a), 64'd1);
        chk("a2_cnt", 64'(w_out_a), 64'({5'd0, 5'd0, 5'd0, 5'd2}));
      end
      r_load_a = (j == 11);
      r_ivl_a  = (j == 11) ? 4'd2 : 4'd6;
      r_cin_a  = 4'b0001;
    end

    // B: ACKNOWLEDGE, interval 3, all channels high.
    @(negedge clk); r_load_b = 1'b1; r_ivl_b = 8'd3; r_cin_b = 4'b1111;
    for (int j = 0; j <= 24; j++) begin
      @(negedge clk);
      if (j == 3 || j == 13 || j == 17) begin
        chk("b3_val", 64'(w_val_b), 64'd1);
        chk("b3_cnt", 64'(w_out_b), 64'({8'd3, 8'd3, 8'd3, 8'd3}));
      end
      if (j == 14) chk("b_ack_drop", 64'(w_val_b), 64'd0);
      if (j == 19) chk("b_load_drop", 64'(w_val_b), 64'd0);
      if (j == 22) chk("b_load_wins", 64'(w_val_b), 64'd0);
      if (j == 24) begin
        chk("b5_val", 64'(w_val_b), 64'd1);
        chk("b5_cnt", 64'(w_out_b), 64'({8'd5, 8'd5, 8'd5, 8'd5}));
      end
      r_load_b = (j == 18);
      r_ivl_b  = (j == 18) ? 8'd5 : 8'd3;
      r_ack_b  = (j == 13) || (j == 18);
    end

    // C: saturation with CNT_WIDTH=3, interval 10.
    @(negedge clk); r_load_c = 1'b1; r_ivl_c = 8'd10; r_cin_c = 2'b01;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      if (j == 10) begin
        chk("c_sat_cnt", 64'(w_out_c), 64'({3'd0, 3'd7}));
        chk("c_sat_ovf", 64'(w_ovf_c), 64'd1);
      end
      if (j == 20) begin
        chk("c5_cnt", 64'(w_out_c), 64'({3'd0, 3'd5}));
        chk("c5_ovf", 64'(w_ovf_c), 64'd0);
      end
      r_load_c = 1'b0;
      r_cin_c  = (j >= 15) ? 2'b00 : 2'b01;
    end

    // Asynchronous reset mid-window (A, C) and during HOLD (B).
    @(negedge clk); r_cin_a = 4'b0001; r_cin_b = 4'b0000; r_cin_c = 2'b10;
    chk("b_in_hold", 64'(w_val_b), 64'd1);
    #2 r_rst_n = 1'b0;
    #1;
    chk("arst_out_a", 64'(w_out_a), 64'd0);
    chk("arst_out_b", 64'(w_out_b), 64'd0);
    chk("arst_val_b", 64'(w_val_b), 64'd0);
    chk("arst_ovf_c", 64'(w_ovf_c), 64'd0);
    @(negedge clk); #2 r_rst_n = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == 3) begin
        chk("rel_val_b", 64'(w_val_b), 64'd1);
        chk("rel_cnt_b", 64'(w_out_b), 64'd0);
      end
      if (j == 9) chk("rel_c_early", 64'(w_val_c), 64'd0);
      if (j == 10) begin
        chk("rel_cnt_c", 64'(w_out_c), 64'({3'd7, 3'd0}));
        chk("rel_ovf_c", 64'(w_ovf_c), 64'(2'b10));
      end
      if (j == 16) begin
        chk("rel_val_a", 64'(w_val_a), 64'd1);
        chk("rel_cnt_a", 64'(w_out_a), 64'({5'd0, 5'd0, 5'd0, 5'd16}));
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
